// File: rtl/alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// alu_issue_decoder
//
// Decode stage in front of the ALU. It takes a fetched MIPS instruction and
// the two register-read values, and produces the ALU controls (alu_in1,
// alu_in2, alushamt, alufunct) plus the destination register and its write
// enable. The result is registered and handed on with a valid/ready
// handshake. A 2-entry buffer (main register + skid register) lets the
// execute stage stall without a combinational ready path back to fetch.
//
// Optional feature macro: DECODE_EXC_EN
//   defined   - adds the out_illegal port. Reserved instructions are emitted
//               as a NOP with out_illegal=1, and the flag moves through the
//               skid register together with its entry.
//   undefined - no out_illegal port. Reserved instructions become silent NOPs.
//
// Parameters
//   DATA_W      operand width (32 for MIPS32)
//   SKID_DEPTH  output buffer entries; only 2 is supported
//   LUI_SHAMT   shift amount for LUI (decoded as SLL of the zero-extended imm)
//
// Ports
//   clk          in   clock, rising edge
//   resetn       in   synchronous active-low reset
//   flush        in   drop all buffered entries (redirect)
//   in_valid     in   instruction + operands valid
//   in_ready     out  stage can accept (= !skid valid, registered)
//   in_instr     in   instruction word
//   in_rs_val    in   GPR[rs]
//   in_rt_val    in   GPR[rt]
//   out_valid    out  decoded entry valid
//   out_ready    in   execute stage accepts
//   out_in1      out  alu_in1
//   out_in2      out  alu_in2
//   out_shamt    out  alushamt
//   out_funct    out  alufunct
//   out_dst      out  destination GPR
//   out_wen      out  GPR write enable
//   out_illegal  out  reserved-instruction flag (DECODE_EXC_EN only)
// ---------------------------------------------------------------------------
module alu_issue_decoder #(
  parameter int DATA_W     = 32,
  parameter int SKID_DEPTH = 2,
  parameter int LUI_SHAMT  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_in1,
  output logic [DATA_W-1:0] out_in2,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [4:0]        out_dst,
  output logic              out_wen
`ifdef DECODE_EXC_EN
  ,
  output logic              out_illegal
`endif
);

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  // ALU function codes (SPECIAL funct field)
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  if (SKID_DEPTH != 2) begin : g_depth_check
    $error("alu_issue_decoder: SKID_DEPTH must be 2");
  end

  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [4:0]        dst;
    logic              wen;
`ifdef DECODE_EXC_EN
    logic              illegal;
`endif
  } dec_t;

  function automatic logic is_legal(input logic [31:0] instr);
    logic ok;
    ok = 1'b0;
    case (instr[31:26])
      OP_SPECIAL: begin
        case (instr[5:0])
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_JR: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Illegal encodings fall through with the all-zero NOP (SLL, operands 0).
  function automatic dec_t decode(input logic [31:0]       instr,
                                  input logic [DATA_W-1:0] rs_val,
                                  input logic [DATA_W-1:0] rt_val);
    dec_t                     d;
    logic signed [15:0]       imm_s;
    logic signed [DATA_W-1:0] imm_sx;
    logic        [DATA_W-1:0] imm_zx;
    d      = '0;
    imm_s  = signed'(instr[15:0]);
    imm_sx = DATA_W'(imm_s);
    imm_zx = DATA_W'(instr[15:0]);
    if (is_legal(instr)) begin
      d.in1 = rs_val;
      if (instr[31:26] == OP_SPECIAL) begin
        d.in2   = rt_val;
        d.shamt = instr[10:6];
        d.funct = instr[5:0];
        d.dst   = instr[15:11];
        d.wen   = (instr[15:11] != 5'd0) && (instr[5:0] != FN_JR);
      end else begin
        d.dst = instr[20:16];
        d.wen = (instr[20:16] != 5'd0);
        case (instr[31:26])
          OP_ADDIU: begin d.funct = FN_ADDU; d.in2 = imm_sx; end
          OP_SLTI:  begin d.funct = FN_SLT;  d.in2 = imm_sx; end
          OP_SLTIU: begin d.funct = FN_SLTU; d.in2 = imm_sx; end
          OP_ANDI:  begin d.funct = FN_AND;  d.in2 = imm_zx; end
          OP_ORI:   begin d.funct = FN_OR;   d.in2 = imm_zx; end
          OP_XORI:  begin d.funct = FN_XOR;  d.in2 = imm_zx; end
          default: begin
            d.funct = FN_SLL;
            d.in2   = imm_zx;
            d.shamt = 5'(LUI_SHAMT);
          end
        endcase
      end
    end
`ifdef DECODE_EXC_EN
    d.illegal = !is_legal(instr);
`endif
    return d;
  endfunction

  // The rs index is resolved by the register file before this stage.
  logic unused_rs_field;
  assign unused_rs_field = ^in_instr[25:21];

  // ---- stage p0: combinational decode + handshake ----
  dec_t dec_p0;
  logic in_xfer_p0;
  logic vld_p1;
  logic skid_vld_p1;
  dec_t main_p1;
  dec_t skid_p1;

  assign dec_p0     = decode(in_instr, in_rs_val, in_rt_val);
  assign in_ready   = !skid_vld_p1;
  assign in_xfer_p0 = in_valid && in_ready;

  // ---- stage p1: main register (drives out_*) + skid register ----
  // Main reloads whenever it is empty or draining this cycle; a buffered
  // skid entry always goes first so order stays FIFO. When main is held,
  // an accepted entry parks in skid and in_ready drops the next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || out_ready) begin
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (in_xfer_p0) begin
        main_p1 <= dec_p0;
        vld_p1  <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (in_xfer_p0) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign out_valid = vld_p1;
  assign out_in1   = main_p1.in1;
  assign out_in2   = main_p1.in2;
  assign out_shamt = main_p1.shamt;
  assign out_funct = main_p1.funct;
  assign out_dst   = main_p1.dst;
  assign out_wen   = main_p1.wen;
`ifdef DECODE_EXC_EN
  assign out_illegal = main_p1.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_decoder.sv
`timescale 1ns/1ps
module tb_alu_issue_decoder;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr  = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [4:0]  out_dst;
  logic        out_wen;
`ifdef DECODE_EXC_EN
  logic        out_illegal;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [4:0]  dst;
    logic        wen;
    logic        illegal;
  } exp_t;

  exp_t sb[$];

  alu_issue_decoder dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_rs_val (in_rs_val),
    .in_rt_val (in_rt_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_in1   (out_in1),
    .out_in2   (out_in2),
    .out_shamt (out_shamt),
    .out_funct (out_funct),
    .out_dst   (out_dst),
    .out_wen   (out_wen)
`ifdef DECODE_EXC_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Reference decode written from the instruction table.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] sx;
    logic [31:0] zx;
    op = ins[31:26];
    fn = ins[5:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    e.in1 = '0; e.in2 = '0; e.shamt = '0; e.funct = '0; e.dst = '0; e.wen = 1'b0; e.illegal = 1'b1;
    if (op == 6'h00) begin
      if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08}) begin
        e.in1 = rs; e.in2 = rt; e.shamt = ins[10:6]; e.funct = fn; e.dst = ins[15:11];
        e.wen = (ins[15:11] != 5'd0) && (fn != 6'h08);
        e.illegal = 1'b0;
      end
    end else if (op >= 6'h09 && op <= 6'h0f) begin
      e.in1 = rs; e.dst = ins[20:16]; e.wen = (ins[20:16] != 5'd0); e.illegal = 1'b0;
      case (op)
        6'h09:   begin e.funct = 6'h21; e.in2 = sx; end
        6'h0a:   begin e.funct = 6'h2a; e.in2 = sx; end
        6'h0b:   begin e.funct = 6'h2b; e.in2 = sx; end
        6'h0c:   begin e.funct = 6'h24; e.in2 = zx; end
        6'h0d:   begin e.funct = 6'h25; e.in2 = zx; end
        6'h0e:   begin e.funct = 6'h26; e.in2 = zx; end
        default: begin e.funct = 6'h00; e.in2 = zx; e.shamt = 5'd16; end
      endcase
    end
    return e;
  endfunction

  // Scoreboard monitor: inputs change just after posedge, so at negedge we
  // see exactly what the next posedge will act on.
  initial begin
    exp_t e;
    exp_t hold;
    logic held;
    logic bad;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn || flush) begin
        sb.delete();
        held = 1'b0;
      end else begin
        if (held) begin
          checks++;
          if (out_in1 !== hold.in1 || out_in2 !== hold.in2 || out_shamt !== hold.shamt ||
              out_funct !== hold.funct || out_dst !== hold.dst || out_wen !== hold.wen ||
              out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_stable got v=%b in1=%h in2=%h fn=%h dst=%0d required in1=%h in2=%h fn=%h dst=%0d",
                     out_valid, out_in1, out_in2, out_funct, out_dst, hold.in1, hold.in2, hold.funct, hold.dst);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got dst=%0d fn=%h required no output", out_dst, out_funct);
          end else begin
            e = sb.pop_front();
            bad = (out_in1 !== e.in1) || (out_in2 !== e.in2) || (out_shamt !== e.shamt) ||
                  (out_funct !== e.funct) || (out_dst !== e.dst) || (out_wen !== e.wen);
`ifdef DECODE_EXC_EN
            bad = bad || (out_illegal !== e.illegal);
`else
            bad = bad || (e.illegal && out_wen !== 1'b0);
`endif
            if (bad) begin
              failures++;
              $display("FAIL sb_entry got in1=%h in2=%h sh=%0d fn=%h dst=%0d wen=%b required in1=%h in2=%h sh=%0d fn=%h dst=%0d wen=%b",
                       out_in1, out_in2, out_shamt, out_funct, out_dst, out_wen,
                       e.in1, e.in2, e.shamt, e.funct, e.dst, e.wen);
            end
          end
        end
        if (in_valid && in_ready) sb.push_back(model(in_instr, in_rs_val, in_rt_val));
        held = out_valid && !out_ready;
        if (held) begin
          hold.in1 = out_in1; hold.in2 = out_in2; hold.shamt = out_shamt;
          hold.funct = out_funct; hold.dst = out_dst; hold.wen = out_wen; hold.illegal = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got timeout required finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed decode table: instr, rs, rt -> expected in1, in2, shamt, funct, dst, wen, illegal
  localparam int NT = 9;
  localparam logic [31:0] T_INS [NT] = '{32'h2422FFFF, 32'h3C031234, 32'h000521C3, 32'h03E00008,
                                         32'h30268001, 32'h28278000, 32'h00220021, 32'hFC221234, 32'h00222820};
  localparam logic [31:0] T_RS  [NT] = '{32'h5, 32'h0, 32'h11, 32'h400, 32'hFFFF0000, 32'h10, 32'hA, 32'h5, 32'h5};
  localparam logic [31:0] T_RT  [NT] = '{32'h77, 32'h9, 32'h80000F00, 32'h3, 32'h1, 32'h2, 32'hB, 32'h6, 32'h6};
  localparam logic [31:0] T_IN1 [NT] = '{32'h5, 32'h0, 32'h11, 32'h400, 32'hFFFF0000, 32'h10, 32'hA, 32'h0, 32'h0};
  localparam logic [31:0] T_IN2 [NT] = '{32'hFFFFFFFF, 32'h00001234, 32'h80000F00, 32'h3, 32'h00008001,
                                         32'hFFFF8000, 32'hB, 32'h0, 32'h0};
  localparam logic [4:0]  T_SH  [NT] = '{5'd0, 5'd16, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  localparam logic [5:0]  T_FN  [NT] = '{6'h21, 6'h00, 6'h03, 6'h08, 6'h24, 6'h2a, 6'h21, 6'h00, 6'h00};
  localparam logic [4:0]  T_DST [NT] = '{5'd2, 5'd3, 5'd4, 5'd0, 5'd6, 5'd7, 5'd0, 5'd0, 5'd0};
  localparam logic        T_WEN [NT] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic        T_ILL [NT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", in_ready); end
    checks++; if (out_in1 !== 32'h0 || out_in2 !== 32'h0) begin failures++;
      $display("FAIL reset_operands got in1=%h in2=%h required 0", out_in1, out_in2); end
    checks++; if (out_funct !== 6'h00 || out_shamt !== 5'd0 || out_dst !== 5'd0 || out_wen !== 1'b0) begin failures++;
      $display("FAIL reset_ctrl got fn=%h sh=%0d dst=%0d wen=%b required 0", out_funct, out_shamt, out_dst, out_wen); end
`ifdef DECODE_EXC_EN
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b required=0", out_illegal); end
`endif
    resetn = 1'b1;
    step();
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    for (int i = 0; i < NT; i++) begin
      in_instr = T_INS[i]; in_rs_val = T_RS[i]; in_rt_val = T_RT[i]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dec%0d_valid got=%b required=1", i, out_valid); end
      checks++; if (out_in1 !== T_IN1[i]) begin failures++; $display("FAIL dec%0d_in1 got=%h required=%h", i, out_in1, T_IN1[i]); end
      checks++; if (out_in2 !== T_IN2[i]) begin failures++; $display("FAIL dec%0d_in2 got=%h required=%h", i, out_in2, T_IN2[i]); end
      checks++; if (out_shamt !== T_SH[i]) begin failures++; $display("FAIL dec%0d_shamt got=%0d required=%0d", i, out_shamt, T_SH[i]); end
      checks++; if (out_funct !== T_FN[i]) begin failures++; $display("FAIL dec%0d_funct got=%h required=%h", i, out_funct, T_FN[i]); end
      checks++; if (out_dst !== T_DST[i]) begin failures++; $display("FAIL dec%0d_dst got=%0d required=%0d", i, out_dst, T_DST[i]); end
      checks++; if (out_wen !== T_WEN[i]) begin failures++; $display("FAIL dec%0d_wen got=%b required=%b", i, out_wen, T_WEN[i]); end
`ifdef DECODE_EXC_EN
      checks++; if (out_illegal !== T_ILL[i]) begin failures++; $display("FAIL dec%0d_illegal got=%b required=%b", i, out_illegal, T_ILL[i]); end
`else
      checks++; if (T_ILL[i] && out_wen !== 1'b0) begin failures++; $display("FAIL dec%0d_illegal_wen got=%b required=0", i, out_wen); end
`endif
    end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dec_drain_valid got=%b required=0", out_valid); end
  endtask

  // Fills main (entry 1) and skid (entry 2) with out_ready low.
  task automatic fill_two();
    out_ready = 1'b0;
    in_rs_val = 32'h0000DEAD; in_rt_val = 32'h0000BEEF;
    in_instr = 32'h24010001; in_valid = 1'b1;
    step();
    in_instr = 32'h24020002;
    step();
  endtask

  task automatic test_back_to_back();
    fill_two();
    checks++; if (in_ready !== 1'b0 || out_dst !== 5'd1) begin failures++;
      $display("FAIL b2b_full got ready=%b dst=%0d required ready=0 dst=1", in_ready, out_dst); end
    in_instr = 32'h24030003;
    step();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dst !== 5'd1) begin failures++;
      $display("FAIL b2b_stall got ready=%b valid=%b dst=%0d required ready=0 valid=1 dst=1", in_ready, out_valid, out_dst); end
    out_ready = 1'b1;
    step();
    checks++; if (out_dst !== 5'd2 || in_ready !== 1'b1 || out_in2 !== 32'h2) begin failures++;
      $display("FAIL b2b_second got dst=%0d ready=%b in2=%h required dst=2 ready=1 in2=2", out_dst, in_ready, out_in2); end
    step();
    in_valid = 1'b0;
    checks++; if (out_dst !== 5'd3 || out_valid !== 1'b1) begin failures++;
      $display("FAIL b2b_third got dst=%0d valid=%b required dst=3 valid=1", out_dst, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b required=0", out_valid); end
  endtask

  task automatic test_flush();
    fill_two();
    flush = 1'b1;
    in_instr = 32'h24030003;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL flush_state got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_replay got=%b required=0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    fill_two();
    in_valid = 1'b0;
    resetn = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL rst_stall_state got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready); end
    checks++; if (out_in1 !== 32'h0 || out_dst !== 5'd0 || out_wen !== 1'b0) begin failures++;
      $display("FAIL rst_stall_data got in1=%h dst=%0d wen=%b required 0", out_in1, out_dst, out_wen); end
    resetn = 1'b1;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_after got=%b required=0", out_valid); end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] ins;
    logic [5:0]  fn_pool [12] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08};
    ins = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin ins[31:26] = 6'h00; ins[5:0] = fn_pool[$urandom_range(0, 11)]; end
      3:       ins[31:26] = 6'h00;
      4:       ins[31:26] = 6'h3f;
      5:       ins[31:26] = 6'h04;
      default: ins[31:26] = 6'(6'h09 + $urandom_range(0, 6));
    endcase
    return ins;
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rnd_instr();
      in_rs_val = $urandom;
      in_rt_val = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8 && out_valid; k++) step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rand_drain got valid=%b required=0", out_valid); end
    step();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_leftover got=%0d required=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
